// File: rtl/hdc_pkg.sv
// hdc_pkg: shared definitions for the HDC spam/ham classifier front end.
//   - Default sizing for the message vector (max length, character width,
//     length width, label width).
//   - Label encodings HAM, SPAM and INCONCLUSIVE (all-ones).
//   - State encoding of the msg_loader FSM.
package hdc_pkg;

  localparam int unsigned DEF_MAX_LEN = 200;
  localparam int unsigned DEF_CHAR_W  = 8;
  localparam int unsigned DEF_LEN_W   = 8;
  localparam int unsigned DEF_LABEL_W = 2;

  localparam logic [DEF_LABEL_W-1:0] HAM          = 2'b00;
  localparam logic [DEF_LABEL_W-1:0] SPAM         = 2'b01;
  localparam logic [DEF_LABEL_W-1:0] INCONCLUSIVE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_REPORT
  } loader_state_t;

endpackage

// File: rtl/msg_pack_buf.sv
// msg_pack_buf: zero-clearable packed message register with per-character
// write. Character index i lives at msg[CHAR_W*(MAX_LEN-i)-1 -: CHAR_W], so
// the first character lands in the top byte.
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-low reset (clears the whole vector)
//   clr      in   synchronous clear of the whole vector
//   wr_en    in   write wr_data at character index wr_idx
//   wr_idx   in   character index (0 = first character)
//   wr_data  in   character to store
//   msg      out  packed message vector
module msg_pack_buf
  import hdc_pkg::*;
#(
  parameter int unsigned MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned CHAR_W  = DEF_CHAR_W,
  parameter int unsigned LEN_W   = DEF_LEN_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clr,
  input  logic                      wr_en,
  input  logic [LEN_W-1:0]          wr_idx,
  input  logic [CHAR_W-1:0]         wr_data,
  output logic [CHAR_W*MAX_LEN-1:0] msg
);

  // One register per character slot; each slot decodes its own write enable,
  // and clear has priority over a write in the same cycle.
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_slot
    logic [CHAR_W-1:0] byte_reg;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        byte_reg <= '0;
      end else if (clr) begin
        byte_reg <= '0;
      end else if (wr_en && (wr_idx == LEN_W'(gi))) begin
        byte_reg <= wr_data;
      end
    end

    assign msg[CHAR_W*(MAX_LEN-gi)-1 -: CHAR_W] = byte_reg;
  end

endmodule

// File: rtl/msg_loader.sv
// msg_loader: byte-stream front end for the HDC spam/ham classifier.
// Accepts one framed message (tag byte, then characters, in_last on the final
// byte), packs it MSB-first into msg/length/label, pulses cls_start, waits for
// cls_done and reports the returned label with a match check against the tag.
// Optional feature macro: MSG_LOADER_SCORE_EN adds saturating correct_cnt /
// total_cnt score counters (ports and logic absent when undefined).
// Ports:
//   clk, reset                  clock; asynchronous active-low reset
//   in_valid/in_ready/in_data/in_last   byte-stream input
//   msg, length, label          packed message, stored char count, frame tag
//   cls_start                   one-cycle start pulse to the classifier
//   cls_done, cls_result        classifier handshake / returned label
//   res_valid                   one-cycle result strobe
//   res_label/res_match/res_inconcl     captured result and its checks
//   overflow                    frame exceeded MAX_LEN (held until next frame)
//   correct_cnt, total_cnt      score counters (MSG_LOADER_SCORE_EN only)
module msg_loader
  import hdc_pkg::*;
#(
  parameter int unsigned MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned CHAR_W  = DEF_CHAR_W,
  parameter int unsigned LEN_W   = DEF_LEN_W,
  parameter int unsigned LABEL_W = DEF_LABEL_W
`ifdef MSG_LOADER_SCORE_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHAR_W-1:0]         in_data,
  input  logic                      in_last,
  output logic [CHAR_W*MAX_LEN-1:0] msg,
  output logic [LEN_W-1:0]          length,
  output logic [LABEL_W-1:0]        label,
  output logic                      cls_start,
  input  logic                      cls_done,
  input  logic [LABEL_W-1:0]        cls_result,
  output logic                      res_valid,
  output logic [LABEL_W-1:0]        res_label,
  output logic                      res_match,
  output logic                      res_inconcl,
  output logic                      overflow
`ifdef MSG_LOADER_SCORE_EN
  , output logic [CNT_W-1:0]        correct_cnt
  , output logic [CNT_W-1:0]        total_cnt
`endif
);

  localparam logic [LEN_W-1:0]   LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [LABEL_W-1:0] ALL_ONES = {LABEL_W{1'b1}};

  loader_state_t       state_reg;
  logic                in_ready_reg;
  logic [LEN_W-1:0]    len_reg;
  logic [LABEL_W-1:0]  label_reg;
  logic                overflow_reg;
  logic                cls_start_reg;
  logic                res_valid_reg;
  logic [LABEL_W-1:0]  res_label_reg;
  logic                res_match_reg;
  logic                res_inconcl_reg;

  logic xfer;
  logic buf_clr;
  logic buf_wr;

  // in_ready is a registered copy of "state is IDLE or LOAD", so a transfer
  // can be qualified directly with it.
  assign xfer    = in_valid && in_ready_reg;
  assign buf_clr = xfer && (state_reg == ST_IDLE);
  assign buf_wr  = xfer && (state_reg == ST_LOAD) && (len_reg < LEN_MAX);

  msg_pack_buf #(
    .MAX_LEN (MAX_LEN),
    .CHAR_W  (CHAR_W),
    .LEN_W   (LEN_W)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .clr     (buf_clr),
    .wr_en   (buf_wr),
    .wr_idx  (len_reg),
    .wr_data (in_data),
    .msg     (msg)
  );

`ifdef MSG_LOADER_SCORE_EN
  logic [CNT_W-1:0] correct_reg;
  logic [CNT_W-1:0] total_reg;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= ST_IDLE;
      in_ready_reg    <= 1'b0;
      len_reg         <= '0;
      label_reg       <= '0;
      overflow_reg    <= 1'b0;
      cls_start_reg   <= 1'b0;
      res_valid_reg   <= 1'b0;
      res_label_reg   <= '0;
      res_match_reg   <= 1'b0;
      res_inconcl_reg <= 1'b0;
`ifdef MSG_LOADER_SCORE_EN
      correct_reg     <= '0;
      total_reg       <= '0;
`endif
    end else begin
      // Strobes default low; they are raised on entry to ISSUE / REPORT.
      cls_start_reg <= 1'b0;
      res_valid_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          in_ready_reg <= 1'b1;
          if (xfer) begin
            label_reg    <= in_data[LABEL_W-1:0];
            len_reg      <= '0;
            overflow_reg <= 1'b0;
            if (in_last) begin
              state_reg     <= ST_ISSUE;
              in_ready_reg  <= 1'b0;
              cls_start_reg <= 1'b1;
            end else begin
              state_reg <= ST_LOAD;
            end
          end
        end

        ST_LOAD: begin
          if (xfer) begin
            // Characters beyond MAX_LEN are accepted but dropped.
            if (len_reg < LEN_MAX) begin
              len_reg <= len_reg + LEN_W'(1);
            end else begin
              overflow_reg <= 1'b1;
            end
            if (in_last) begin
              state_reg     <= ST_ISSUE;
              in_ready_reg  <= 1'b0;
              cls_start_reg <= 1'b1;
            end
          end
        end

        ST_ISSUE: begin
          state_reg <= ST_WAIT;
        end

        ST_WAIT: begin
          if (cls_done) begin
            res_label_reg   <= cls_result;
            res_inconcl_reg <= (cls_result == ALL_ONES);
            res_match_reg   <= (cls_result == label_reg) && (cls_result != ALL_ONES);
            res_valid_reg   <= 1'b1;
            state_reg       <= ST_REPORT;
          end
        end

        ST_REPORT: begin
`ifdef MSG_LOADER_SCORE_EN
          if (total_reg != '1) begin
            total_reg <= total_reg + CNT_W'(1);
          end
          if (res_match_reg && (correct_reg != '1)) begin
            correct_reg <= correct_reg + CNT_W'(1);
          end
`endif
          state_reg    <= ST_IDLE;
          in_ready_reg <= 1'b1;
        end

        default: begin
          state_reg    <= ST_IDLE;
          in_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_reg;
  assign length      = len_reg;
  assign label       = label_reg;
  assign cls_start   = cls_start_reg;
  assign res_valid   = res_valid_reg;
  assign res_label   = res_label_reg;
  assign res_match   = res_match_reg;
  assign res_inconcl = res_inconcl_reg;
  assign overflow    = overflow_reg;
`ifdef MSG_LOADER_SCORE_EN
  assign correct_cnt = correct_reg;
  assign total_cnt   = total_reg;
`endif

endmodule
